// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUO,
    output logic [WIDTH-1:0] REM,
    output logic             DZ
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DIVZ   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dz;

    logic [WIDTH-1:0]   w_p;
    logic [WIDTH:0]     w_t;
    logic               w_borrow;

    // The partial remainder stays below 2^(WIDTH-1) until the final step,
    // so dropping its MSB when shifting never loses information.
    assign w_p      = {r_rem[WIDTH-2:0], r_a[r_cnt]};
    assign w_t      = {1'b0, w_p} - {1'b0, r_b};
    assign w_borrow = w_t[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_quo   <= '0;
                        r_rem   <= '0;
                        r_dz    <= 1'b0;
                        r_cnt   <= c_CNT_MAX;
                        r_state <= (B == '0) ? c_ST_DIVZ : c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_rem        <= w_borrow ? w_p : w_t[WIDTH-1:0];
                    r_quo[r_cnt] <= ~w_borrow;
                    if (r_cnt == '0) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_DIVZ: begin
                    r_quo   <= '1;
                    r_rem   <= r_a;
                    r_dz    <= 1'b1;
                    r_state <= c_ST_DONE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign BUSY = (r_state == c_ST_RUN) || (r_state == c_ST_DIVZ);
    assign DONE = (r_state == c_ST_DONE);
    assign QUO  = r_quo;
    assign REM  = r_rem;
    assign DZ   = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Directed and exhaustive self-checking bench for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] QUO;
    logic [W-1:0] REM;
    logic         DZ;

    int vectors     = 0;
    int miscompares = 0;
    int n_started   = 0;
    int n_done      = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .QUO   (QUO),
        .REM   (REM),
        .DZ    (DZ)
    );

    always @(negedge clk) begin
        if (rst_n && DONE === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with START dropped.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        A     = a;
        B     = b;
        START = 1'b1;
        n_started++;
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz, input int elat);
        int lat  = 1;
        int busy = 0;
        while (DONE !== 1'b1 && lat < 20) begin
            if (BUSY === 1'b1) busy++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"},  lat, elat);
        check({tag, ".busy"}, busy, elat - 1);
        check({tag, ".quo"},  32'(QUO), 32'(eq));
        check({tag, ".rem"},  32'(REM), 32'(er));
        check({tag, ".dz"},   32'(DZ),  32'(edz));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        @(negedge clk);
        start_op(a, b);
        wait_done(tag, eq, er, edz, (b == '0) ? 2 : W + 1);
    endtask

    initial begin
        int seen;

        // Reset state
        #12;
        check("rst.busy", 32'(BUSY), 0);
        check("rst.done", 32'(DONE), 0);
        check("rst.quo",  32'(QUO),  0);
        check("rst.rem",  32'(REM),  0);
        check("rst.dz",   32'(DZ),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic division, DONE is a single-cycle pulse and results are held
        run_op("t1", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
        @(negedge clk);
        check("t1.done_low", 32'(DONE), 0);
        check("t1.quo_hold", 32'(QUO),  3);
        check("t1.rem_hold", 32'(REM),  1);

        run_op("t2a", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_op("t2b", 4'd3,  4'd9, 4'd0,  4'd3, 1'b0);
        run_op("t2c", 4'd0,  4'd7, 4'd0,  4'd0, 1'b0);

        // Divide by zero, then a normal op clears DZ
        run_op("t3a", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
        run_op("t3b", 4'd6, 4'd3, 4'd2,  4'd0, 1'b0);

        // START while busy is ignored
        @(negedge clk);
        start_op(4'd9, 4'd2);
        @(negedge clk);
        A = 4'd1; B = 4'd1; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        wait_done("t4", 4'd4, 4'd1, 1'b0, W - 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (DONE === 1'b1) seen++;
        end
        check("t4.extra_done", seen, 0);

        // Reset during the second RUN step aborts without DONE
        @(negedge clk);
        A = 4'd13; B = 4'd4; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        check("t5.rem_before", 32'(REM), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5.busy", 32'(BUSY), 0);
        check("t5.done", 32'(DONE), 0);
        check("t5.quo",  32'(QUO),  0);
        check("t5.rem",  32'(REM),  0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (DONE === 1'b1) seen++;
        end
        check("t5.no_done", seen, 0);
        run_op("t5b", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);

        // Back-to-back: START held in the DONE cycle
        start_op(4'd10, 4'd3);
        wait_done("t6", 4'd3, 4'd1, 1'b0, W + 1);

        // Exhaustive sweep against a reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [W-1:0] eq;
                logic [W-1:0] er;
                if (b == 0) begin
                    eq = '1;
                    er = W'(a);
                end else begin
                    eq = W'(a / b);
                    er = W'(a % b);
                end
                run_op($sformatf("sw_%0d_%0d", a, b), W'(a), W'(b), eq, er, b == 0);
            end
        end

        repeat (3) @(negedge clk);
        check("done_count", n_done, n_started);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
